// File: rtl/clk_gen_pkg.sv
// ---------------------------------------------------------------------------
// clk_gen_pkg
// Shared types and defaults for the programmable clock-period generator.
//   gen_state_e  : generator state (IDLE, HIGH, LOW)
//   *_DEFAULT    : default parameter values for counter width and reset phases
//   max1()       : clamps a zero phase length up to one cycle
// ---------------------------------------------------------------------------
package clk_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } gen_state_e;

  localparam int CNT_W_DEFAULT    = 16;
  localparam int RST_HIGH_DEFAULT = 1;
  localparam int RST_LOW_DEFAULT  = 1;

  // A zero-length phase has no meaning, so it is treated as one cycle.
  function automatic logic [31:0] max1(input logic [31:0] x);
    return (x == 32'd0) ? 32'd1 : x;
  endfunction

endpackage

// File: rtl/clk_period_gen_if.sv
// ---------------------------------------------------------------------------
// clk_period_gen_if
// Configuration handshake for clk_period_gen.
//   cfg_valid : new configuration offered (master -> slave)
//   cfg_high  : high-phase length in clk cycles (master -> slave)
//   cfg_low   : low-phase length in clk cycles (master -> slave)
//   cfg_ready : configuration can be accepted (slave -> master)
// ---------------------------------------------------------------------------
interface clk_period_gen_if
  import clk_gen_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) ();

  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_high;
  logic [CNT_W-1:0] cfg_low;
  logic             cfg_ready;

  modport master (
    output cfg_valid,
    output cfg_high,
    output cfg_low,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_high,
    input  cfg_low,
    output cfg_ready
  );

endinterface

// File: rtl/phase_counter.sv
// ---------------------------------------------------------------------------
// phase_counter
// Cycle counter shared by the high and low phases of clk_period_gen.
//   clk, rst_n : clock, asynchronous active-low reset (count returns to 0)
//   clr_i      : clear count to 0 (generator going idle)
//   load_i     : start a new phase, count = 1
//   inc_i      : advance count by one
//   limit_i    : length of the current phase
//   done_o     : count has reached the phase length
// ---------------------------------------------------------------------------
module phase_counter
  import clk_gen_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic             inc_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             done_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // The count starts at 1 on the first cycle of a phase, so equality with the
  // limit marks the last cycle of that phase and the count never wraps.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = CNT_W'(1);
    end else if (inc_i) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == limit_i);

endmodule

// File: rtl/clk_period_gen.sv
// ---------------------------------------------------------------------------
// clk_period_gen
// Programmable clock-period generator. clk_out is high for act_high cycles
// and low for act_low cycles of clk; new settings arrive over a valid/ready
// handshake and are only applied when a new period begins.
//   clk          : system clock
//   rst_n        : asynchronous active-low reset
//   en           : run request; dropping it lets the current period finish
//   cfg          : configuration handshake (slave side)
//   clk_out      : generated clock (registered)
//   period_start : one-cycle pulse on the first cycle of each high phase
//   active       : generator is running (not idle)
// ---------------------------------------------------------------------------
module clk_period_gen
  import clk_gen_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEFAULT,
  parameter int RST_HIGH = RST_HIGH_DEFAULT,
  parameter int RST_LOW  = RST_LOW_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  clk_period_gen_if.slave cfg,
  output logic            clk_out,
  output logic            period_start,
  output logic            active
);

  gen_state_e       state_q, state_d;
  logic             clk_out_q, period_start_q, active_q;
  logic             pend_vld_q, pend_vld_d;
  logic [CNT_W-1:0] pend_high_q, pend_high_d;
  logic [CNT_W-1:0] pend_low_q, pend_low_d;
  logic [CNT_W-1:0] act_high_q, act_high_d;
  logic [CNT_W-1:0] act_low_q, act_low_d;

  logic             cfg_ready;
  logic             accept;
  logic             boundary;
  logic             phase_change;
  logic             cnt_done;
  logic [CNT_W-1:0] cnt_limit;

  // In IDLE the pending slot may be overwritten; while running it holds one
  // configuration until the next period boundary consumes it.
  assign cfg_ready     = (state_q == IDLE) || !pend_vld_q;
  assign cfg.cfg_ready = cfg_ready;
  assign accept        = cfg.cfg_valid && cfg_ready;

  assign cnt_limit = (state_q == LOW) ? act_low_q : act_high_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en) state_d = HIGH;
      HIGH:    if (cnt_done) state_d = LOW;
      LOW:     if (cnt_done) state_d = en ? HIGH : IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign boundary     = (state_d == HIGH) && (state_q != HIGH);
  assign phase_change = (state_d != state_q);

  // The boundary consumes the pending slot as it stood before this edge; a
  // configuration accepted on the same edge refills the slot afterwards and
  // therefore waits for the following boundary.
  always_comb begin
    pend_vld_d  = pend_vld_q;
    pend_high_d = pend_high_q;
    pend_low_d  = pend_low_q;
    act_high_d  = act_high_q;
    act_low_d   = act_low_q;
    if (boundary && pend_vld_q) begin
      act_high_d = pend_high_q;
      act_low_d  = pend_low_q;
      pend_vld_d = 1'b0;
    end
    if (accept) begin
      pend_high_d = CNT_W'(max1(32'(cfg.cfg_high)));
      pend_low_d  = CNT_W'(max1(32'(cfg.cfg_low)));
      pend_vld_d  = 1'b1;
    end
  end

  // Outputs are decoded from the next state so they come straight from flops
  // and line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      clk_out_q      <= 1'b0;
      period_start_q <= 1'b0;
      active_q       <= 1'b0;
      pend_vld_q     <= 1'b0;
      pend_high_q    <= '0;
      pend_low_q     <= '0;
      act_high_q     <= CNT_W'(RST_HIGH);
      act_low_q      <= CNT_W'(RST_LOW);
    end else begin
      state_q        <= state_d;
      clk_out_q      <= (state_d == HIGH);
      period_start_q <= boundary;
      active_q       <= (state_d != IDLE);
      pend_vld_q     <= pend_vld_d;
      pend_high_q    <= pend_high_d;
      pend_low_q     <= pend_low_d;
      act_high_q     <= act_high_d;
      act_low_q      <= act_low_d;
    end
  end

  // Every state change starts a fresh phase except the return to IDLE.
  phase_counter #(
    .CNT_W (CNT_W)
  ) u_phase_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (phase_change && (state_d == IDLE)),
    .load_i  (phase_change && (state_d != IDLE)),
    .inc_i   (!phase_change && (state_q != IDLE)),
    .limit_i (cnt_limit),
    .done_o  (cnt_done)
  );

  assign clk_out      = clk_out_q;
  assign period_start = period_start_q;
  assign active       = active_q;

endmodule

// File: doc/clk_period_gen.md
Name: clk_period_gen

Overview:
- Programmable clock-period generator: produces a divided output clock `clk_out` whose high and low phases are set in `clk` cycles.
- It is the source side of the period-check flow: it drives the clocks that our period assertions measure, so every period it produces is exactly known and cycle-precise.
- Reconfiguration uses a valid/ready handshake and takes effect only at a period boundary, so `clk_out` never glitches.

Parameters:
- CNT_W, 16, width of the high/low phase counts.
- RST_HIGH, 1, high-phase length in cycles loaded at reset.
- RST_LOW, 1, low-phase length in cycles loaded at reset.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  run request.
- cfg_valid  in  1  new configuration offered.
- cfg_high  in  CNT_W  high-phase length, in clk cycles.
- cfg_low  in  CNT_W  low-phase length, in clk cycles.
- cfg_ready  out  1  configuration can be accepted.
- clk_out  out  1  generated clock, registered.
- period_start  out  1  one-cycle pulse on the first cycle of each high phase.
- active  out  1  generator running (state != IDLE).

Behaviour:
- Reset (async assert, sync release) gives: state IDLE, clk_out=0, period_start=0, active=0, cfg_ready=1, pend_vld=0, act_high=RST_HIGH, act_low=RST_LOW, counter=0.
- States: IDLE, HIGH, LOW.
- A value of 0 on cfg_high or cfg_low is clamped to 1 at accept.
- Accept happens when cfg_valid && cfg_ready. The clamped values go into pend_high/pend_low and pend_vld is set on the next edge.
- cfg_ready = (state==IDLE) || !pend_vld. In IDLE a new accept overwrites the pending configuration.
- Boundary = any transition into HIGH, either IDLE->HIGH or LOW->HIGH.
  - At a boundary, if pend_vld is set, act_* is loaded from pend_* and pend_vld is cleared.
  - That period and all later ones use the loaded values.
- A configuration accepted in the same cycle as a boundary does not apply at that boundary; it applies at the next one.
- IDLE: if en is set, go to HIGH on the next edge. In HIGH: clk_out=1, period_start=1 for one cycle, counter=1.
- HIGH: when counter==act_high, go to LOW (clk_out=0, counter=1); otherwise increment counter.
- LOW: when counter==act_low, leave LOW:
  - if en, go to HIGH (new period, period_start=1);
  - else go to IDLE (clk_out=0, active=0).
  Otherwise increment counter.
- Period is exactly act_high+act_low clk cycles; duty cycle is act_high/(act_high+act_low).
- Deasserting en mid-period never truncates: the current period completes, then the block goes idle.
- Re-asserting en while still in LOW continues with no gap.
- Minimum setting high=1, low=1 gives a divide-by-2 clock with a pulse every 2 cycles.
- Counter is CNT_W bits and never wraps, because the compare terminates each phase at most at 2^CNT_W-1.
- rst_n asserted mid-period forces all reset values immediately (asynchronously). The pending configuration is discarded.
- clk_out, period_start and active are all driven directly from flops.

Decomposition:
- Package clk_gen_pkg holds:
  - `gen_state_e` enum (IDLE, HIGH, LOW);
  - localparam defaults for CNT_W, RST_HIGH, RST_LOW;
  - a clamp function max1(x).
- One natural sub-module: phase_counter (load/increment/compare-equal against a limit, outputs `done`). It is instantiated once and shared across phases.

Test Plan:
- Reset then en=1 with default config → clk_out toggles every cycle; period_start every 2 cycles; first rising edge of clk_out 1 cycle after en sampled.
- In IDLE accept high=3, low=5, then en=1 → clk_out high for 3 cycles and low for 5; measured period 8 cycles, stable over 4 periods; active=1 throughout.
- While running at 3/5, accept high=2, low=2 mid-HIGH:
  - cfg_ready drops the next cycle;
  - the current period stays 8 cycles;
  - the next period is 4 cycles;
  - cfg_ready returns high after that boundary.
- cfg_valid asserted exactly on the LOW->HIGH cycle → new values take effect one period later; the period in progress keeps the old 3/5.
- Drop en during the HIGH of a 3/5 period → the remaining high and all 5 low cycles complete, then IDLE with clk_out=0 and active=0; no truncated pulse.
- Accept cfg_high=0, cfg_low=0 → behaves as 1/1 (period 2). Also assert rst_n low mid-LOW → all outputs 0, cfg_ready=1, and the pending configuration is lost.
